// File: rtl/rx_chain_dig_multi_pkg.sv
// Shared definitions for the multi-channel RX digital merge stage:
// capture-mode encodings and the legal range for the number of replaced LSBs.
package rx_dig_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_CATCH  = 2'b01
    } mode_e;

    localparam int DIG_BITS_MIN = 1;
    localparam int DIG_BITS_MAX = 4;

    function automatic bit dig_bits_legal(input int n);
        return (n >= DIG_BITS_MIN) && (n <= DIG_BITS_MAX);
    endfunction

endpackage

// File: rtl/rx_chain_dig_multi_if.sv
// Sample/config bus between the decimators, GPIO capture and the merge stage.
// The producer side uses the master modport; the merge stage uses slave.
interface rx_chain_dig_multi_if #(
    parameter int NCHAN    = 2,
    parameter int SAMP_W   = 16,
    parameter int DIG_BITS = 1,
    parameter int DLY_W    = 4
);

    logic                       enable;
    logic [1:0]                 mode;
    logic [DLY_W-1:0]           delay;
    logic                       strobe_in;
    logic [NCHAN*SAMP_W-1:0]    i_in_ana;
    logic [NCHAN*SAMP_W-1:0]    q_in_ana;
    logic [NCHAN*DIG_BITS-1:0]  i_in_dig;
    logic [NCHAN*DIG_BITS-1:0]  q_in_dig;
    logic                       strobe_out;
    logic [NCHAN*SAMP_W-1:0]    i_out;
    logic [NCHAN*SAMP_W-1:0]    q_out;

    modport master (
        output enable, mode, delay, strobe_in,
        output i_in_ana, q_in_ana, i_in_dig, q_in_dig,
        input  strobe_out, i_out, q_out
    );

    modport slave (
        input  enable, mode, delay, strobe_in,
        input  i_in_ana, q_in_ana, i_in_dig, q_in_dig,
        output strobe_out, i_out, q_out
    );

endinterface

// File: rtl/rx_chain_dig_multi_delay.sv
// One lane of GPIO capture: catch accumulator, circular alignment buffer
// indexed per strobe, and a bypass for zero delay.
module rx_dig_delay #(
    parameter int DIG_BITS = 1,
    parameter int MAX_DLY  = 16,
    parameter int DLY_W    = $clog2(MAX_DLY)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                strobe_i,
    input  logic                catch_i,
    input  logic [DLY_W-1:0]    delay_i,
    input  logic [DIG_BITS-1:0] dig_i,
    output logic [DIG_BITS-1:0] aligned_o
);

    logic [DIG_BITS-1:0] acc_q;
    logic [DLY_W-1:0]    wp_q;
    logic [DIG_BITS-1:0] mem_q [MAX_DLY];
    logic [DIG_BITS-1:0] cap;
    logic [DLY_W-1:0]    rd_ptr;

    // A bit arriving on the strobe cycle belongs to the sample being captured.
    assign cap    = catch_i ? (acc_q | dig_i) : dig_i;
    // MAX_DLY is a power of two, so the pointer wraps by plain overflow.
    assign rd_ptr = wp_q - delay_i;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        aligned_o = cap;
        if (delay_i != '0) begin
            aligned_o = mem_q[rd_ptr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
            wp_q  <= '0;
            // NOTE: the buffer is cleared on reset because unwritten entries
            // must read as zero; this rules out a plain RAM macro.
            for (int i = 0; i < MAX_DLY; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            acc_q <= strobe_i ? '0 : (acc_q | dig_i);
            if (strobe_i) begin
                mem_q[wp_q] <= cap;
                wp_q        <= wp_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_chain_dig_multi.sv
// Multi-channel RX digital merge: replaces the low DIG_BITS of each I/Q sample
// with captured, delay-aligned GPIO bits; one-clock registered latency.
module rx_chain_dig_multi
    import rx_dig_pkg::*;
#(
    parameter int NCHAN    = 2,
    parameter int SAMP_W   = 16,
    parameter int DIG_BITS = 1,
    parameter int MAX_DLY  = 16,
    parameter int DLY_W    = $clog2(MAX_DLY)
) (
    input  logic               clock,
    input  logic               reset,
    rx_chain_dig_multi_if.slave bus
);

    if (!dig_bits_legal(DIG_BITS)) begin : g_bad_dig_bits
        $error("rx_chain_dig_multi: DIG_BITS must be in 1..4");
    end

    logic                    en_q;
    logic [1:0]              mode_q;
    logic [DLY_W-1:0]        dly_q;
    logic                    en_eff;
    logic [1:0]              mode_eff;
    logic [DLY_W-1:0]        dly_eff;
    logic                    catch_eff;
    logic [DIG_BITS-1:0]     aligned_i [NCHAN];
    logic [DIG_BITS-1:0]     aligned_q [NCHAN];
    logic                    strobe_q;
    logic [NCHAN*SAMP_W-1:0] i_q, i_d;
    logic [NCHAN*SAMP_W-1:0] q_q, q_d;

    // Config applies from the strobe that latches it; between strobes the
    // shadow copy is in force.
    assign en_eff    = bus.strobe_in ? bus.enable : en_q;
    assign mode_eff  = bus.strobe_in ? bus.mode   : mode_q;
    assign dly_eff   = bus.strobe_in ? bus.delay  : dly_q;
    assign catch_eff = (mode_eff == MODE_CATCH);

    always_ff @(posedge clock) begin
        if (reset) begin
            en_q   <= 1'b0;
            mode_q <= MODE_DIRECT;
            dly_q  <= '0;
        end else if (bus.strobe_in) begin
            en_q   <= bus.enable;
            mode_q <= bus.mode;
            dly_q  <= bus.delay;
        end
    end

    for (genvar ch = 0; ch < NCHAN; ch++) begin : g_chan
        rx_dig_delay #(
            .DIG_BITS (DIG_BITS),
            .MAX_DLY  (MAX_DLY),
            .DLY_W    (DLY_W)
        ) u_lane_i (
            .clock     (clock),
            .reset     (reset),
            .strobe_i  (bus.strobe_in),
            .catch_i   (catch_eff),
            .delay_i   (dly_eff),
            .dig_i     (bus.i_in_dig[ch*DIG_BITS +: DIG_BITS]),
            .aligned_o (aligned_i[ch])
        );

        rx_dig_delay #(
            .DIG_BITS (DIG_BITS),
            .MAX_DLY  (MAX_DLY),
            .DLY_W    (DLY_W)
        ) u_lane_q (
            .clock     (clock),
            .reset     (reset),
            .strobe_i  (bus.strobe_in),
            .catch_i   (catch_eff),
            .delay_i   (dly_eff),
            .dig_i     (bus.q_in_dig[ch*DIG_BITS +: DIG_BITS]),
            .aligned_o (aligned_q[ch])
        );
    end

    always_comb begin
        i_d = i_q;
        q_d = q_q;
        if (bus.strobe_in) begin
            i_d = bus.i_in_ana;
            q_d = bus.q_in_ana;
            if (en_eff) begin
                for (int ch = 0; ch < NCHAN; ch++) begin
                    i_d[ch*SAMP_W +: DIG_BITS] = aligned_i[ch];
                    q_d[ch*SAMP_W +: DIG_BITS] = aligned_q[ch];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            strobe_q <= 1'b0;
            i_q      <= '0;
            q_q      <= '0;
        end else begin
            strobe_q <= bus.strobe_in;
            i_q      <= i_d;
            q_q      <= q_d;
        end
    end

    assign bus.strobe_out = strobe_q;
    assign bus.i_out      = i_q;
    assign bus.q_out      = q_q;

endmodule

// File: tb/tb_rx_chain_dig_multi.sv
// Directed bench for rx_chain_dig_multi with a sample-history reference model
// compared every cycle, plus hand-computed expectations for the key scenarios.
module tb_rx_chain_dig_multi;

    localparam int NCHAN    = 2;
    localparam int SAMP_W   = 16;
    localparam int DB       = 2;
    localparam int MAX_DLY  = 16;
    localparam int DLY_W    = 4;
    localparam int NLANE    = 2 * NCHAN;
    localparam int HIST_MAX = 4096;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks   = 0;
    int failures = 0;

    rx_chain_dig_multi_if #(
        .NCHAN    (NCHAN),
        .SAMP_W   (SAMP_W),
        .DIG_BITS (DB),
        .DLY_W    (DLY_W)
    ) bus ();

    rx_chain_dig_multi #(
        .NCHAN    (NCHAN),
        .SAMP_W   (SAMP_W),
        .DIG_BITS (DB),
        .MAX_DLY  (MAX_DLY),
        .DLY_W    (DLY_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every captured word since reset is kept in order, so the
    // aligned word is simply the capture from `delay` samples ago.
    logic [DB-1:0]           m_hist [NLANE][HIST_MAX];
    logic [DB-1:0]           m_seen [NLANE];
    int                      m_cnt = 0;
    logic [NCHAN*SAMP_W-1:0] exp_i = '0;
    logic [NCHAN*SAMP_W-1:0] exp_q = '0;
    logic                    exp_stb = 1'b0;
    bit                      model_on = 1'b0;

    always @(posedge clock) begin : model
        int            ch;
        int            dly;
        logic [DB-1:0] dig;
        logic [DB-1:0] cap;
        logic [DB-1:0] al;
        if (reset) begin
            exp_i   = '0;
            exp_q   = '0;
            exp_stb = 1'b0;
            m_cnt   = 0;
            for (int l = 0; l < NLANE; l++) m_seen[l] = '0;
        end else begin
            exp_stb = bus.strobe_in;
            dly     = int'(bus.delay);
            for (int l = 0; l < NLANE; l++) begin
                ch  = l / 2;
                dig = (l % 2 == 0) ? bus.i_in_dig[ch*DB +: DB] : bus.q_in_dig[ch*DB +: DB];
                if (bus.strobe_in) begin
                    cap = (bus.mode == 2'b01) ? (m_seen[l] | dig) : dig;
                    if (dly == 0)          al = cap;
                    else if (m_cnt >= dly) al = m_hist[l][m_cnt - dly];
                    else                   al = '0;
                    if (m_cnt < HIST_MAX) m_hist[l][m_cnt] = cap;
                    if (l == 0) begin
                        exp_i = bus.i_in_ana;
                        exp_q = bus.q_in_ana;
                    end
                    if (bus.enable) begin
                        if (l % 2 == 0) exp_i[ch*SAMP_W +: DB] = al;
                        else            exp_q[ch*SAMP_W +: DB] = al;
                    end
                    m_seen[l] = '0;
                end else begin
                    m_seen[l] = m_seen[l] | dig;
                end
            end
            if (bus.strobe_in) m_cnt++;
        end
    end

    always @(posedge clock) begin
        #1;
        if (model_on) begin
            check("model_strobe_out", bus.strobe_out, exp_stb);
            check("model_i_out", bus.i_out, exp_i);
            check("model_q_out", bus.q_out, exp_q);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic strobe_once();
        bus.strobe_in = 1'b1;
        @(negedge clock);
        bus.strobe_in = 1'b0;
    endtask

    bit dly_dig [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    bit dly_exp [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        bus.enable    = 1'b0;
        bus.mode      = 2'b00;
        bus.delay     = '0;
        bus.strobe_in = 1'b0;
        bus.i_in_ana  = '0;
        bus.q_in_ana  = '0;
        bus.i_in_dig  = '0;
        bus.q_in_dig  = '0;
        reset         = 1'b1;
        idle(3);
        check("reset_strobe_out", bus.strobe_out, 1'b0);
        check("reset_i_out", bus.i_out, 32'h0);
        check("reset_q_out", bus.q_out, 32'h0);
        model_on = 1'b1;
        reset    = 1'b0;

        // Pass-through with merge disabled: GPIO bits must be ignored.
        bus.i_in_ana = 32'h5555_ABCD;
        bus.q_in_ana = 32'h0F0F_1357;
        bus.i_in_dig = 4'hF;
        bus.q_in_dig = 4'hF;
        strobe_once();
        check("pass_i0", bus.i_out[15:0], 16'hABCD);
        check("pass_q0", bus.q_out[15:0], 16'h1357);
        check("pass_strobe", bus.strobe_out, 1'b1);
        idle(1);
        check("pass_strobe_once", bus.strobe_out, 1'b0);
        check("pass_hold", bus.i_out[15:0], 16'hABCD);

        // Direct merge, zero delay.
        bus.enable   = 1'b1;
        bus.mode     = 2'b00;
        bus.delay    = 4'd0;
        bus.i_in_ana = 32'hFFFF_1234;
        bus.i_in_dig = 4'b00_11;
        bus.q_in_ana = 32'h8000_0001;
        bus.q_in_dig = 4'b10_00;
        strobe_once();
        check("direct_i0", bus.i_out[15:0], 16'h1237);
        check("direct_i1", bus.i_out[31:16], 16'hFFFC);
        check("direct_q0", bus.q_out[15:0], 16'h0000);
        check("direct_q1", bus.q_out[31:16], 16'h8002);

        // Catch mode, strobes every 8 clocks, pulse on clock 3 of the interval.
        bus.mode     = 2'b01;
        bus.i_in_ana = '0;
        bus.q_in_ana = '0;
        bus.i_in_dig = '0;
        bus.q_in_dig = '0;
        strobe_once();
        idle(2);
        bus.i_in_dig = 4'b0001;
        @(negedge clock);
        bus.i_in_dig = '0;
        idle(4);
        strobe_once();
        check("catch_hit", bus.i_out[1:0], 2'b01);
        idle(7);
        strobe_once();
        check("catch_next_clear", bus.i_out[1:0], 2'b00);
        idle(7);
        bus.i_in_dig = 4'b0001;
        strobe_once();
        bus.i_in_dig = '0;
        check("catch_coincident", bus.i_out[1:0], 2'b01);
        idle(7);
        strobe_once();
        check("catch_coincident_next", bus.i_out[1:0], 2'b00);

        // Delay of 3 samples on a fresh buffer, then a live change to 1.
        reset = 1'b1;
        @(negedge clock);
        reset        = 1'b0;
        bus.mode     = 2'b00;
        bus.enable   = 1'b1;
        bus.delay    = 4'd3;
        bus.i_in_ana = 32'h0000_A5A4;
        for (int k = 0; k < 8; k++) begin
            bus.i_in_dig = {3'b000, dly_dig[k]};
            strobe_once();
            check($sformatf("delay3_s%0d", k), bus.i_out[15:0], {14'h2969, 1'b0, dly_exp[k]});
            idle(1);
        end
        bus.delay    = 4'd1;
        idle(1);
        bus.i_in_dig = 4'b0001;
        strobe_once();
        check("delay1_s8", bus.i_out[15:0], 16'hA5A4);
        idle(1);
        bus.i_in_dig = 4'b0000;
        strobe_once();
        check("delay1_s9", bus.i_out[15:0], 16'hA5A5);

        // Reset in the middle of a stream with delay 5; coincident strobe dropped.
        bus.delay    = 4'd5;
        bus.i_in_dig = 4'b0001;
        for (int k = 0; k < 7; k++) strobe_once();
        reset         = 1'b1;
        bus.strobe_in = 1'b1;
        @(negedge clock);
        check("midrst_i_out", bus.i_out, 32'h0);
        check("midrst_q_out", bus.q_out, 32'h0);
        check("midrst_strobe_out", bus.strobe_out, 1'b0);
        reset         = 1'b0;
        bus.strobe_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            strobe_once();
            check($sformatf("postrst_s%0d", k), bus.i_out[15:0], (k < 5) ? 16'hA5A4 : 16'hA5A5);
            idle(1);
        end

        // Enable toggled between strobes has no effect; held change applies at next strobe.
        bus.delay    = 4'd0;
        bus.enable   = 1'b1;
        bus.i_in_ana = 32'h0000_1234;
        bus.i_in_dig = 4'b0011;
        strobe_once();
        check("cfg_base", bus.i_out[15:0], 16'h1237);
        bus.enable = 1'b0;
        @(negedge clock);
        check("cfg_hold_low", bus.i_out[15:0], 16'h1237);
        bus.enable = 1'b1;
        idle(2);
        check("cfg_hold_back", bus.i_out[15:0], 16'h1237);
        strobe_once();
        check("cfg_restrobe", bus.i_out[15:0], 16'h1237);
        bus.enable = 1'b0;
        idle(2);
        strobe_once();
        check("cfg_disable_applied", bus.i_out[15:0], 16'h1234);

        // Reserved mode behaves as direct: a pulse between strobes is lost.
        bus.enable   = 1'b1;
        bus.mode     = 2'b10;
        bus.i_in_dig = '0;
        idle(1);
        bus.i_in_dig = 4'b0001;
        @(negedge clock);
        bus.i_in_dig = '0;
        idle(1);
        strobe_once();
        check("reserved_mode_direct", bus.i_out[15:0], 16'h1234);

        // Near full-rate strobes with shifting config, checked by the model.
        for (int i = 0; i < 48; i++) begin
            bus.strobe_in = (i % 4 != 3);
            bus.mode      = (i < 24) ? 2'b01 : 2'(i % 4);
            bus.delay     = 4'(i % 7);
            bus.enable    = (i % 6 != 5);
            bus.i_in_dig  = 4'(i * 5);
            bus.q_in_dig  = ~4'(i);
            bus.i_in_ana  = 32'(i) * 32'h0101_0101;
            bus.q_in_ana  = 32'hFFFF_FFFF - 32'(i) * 32'h0003_0007;
            @(negedge clock);
        end
        bus.strobe_in = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
